// File: rtl/counter_pkg.sv
// Shared state encoding and direction constants for the triangular sweep controller.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_sweep_ctrl_core.sv
// Loadable up/down counter datapath; load has priority over the enabled step.
module sweep_count_core
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up_down,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= data;
    end else if (en) begin
      r_q <= (up_down == DIR_UP) ? WIDTH'(r_q + 1'b1) : WIDTH'(r_q - 1'b1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequences the counter core through lo->hi->lo sweeps between latched bounds,
// with stop abort, bound validation and finite/continuous sweep counting.
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo_bound,
  input  logic [WIDTH-1:0]   hi_bound,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic [WIDTH-1:0]   cnt_out,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_lo, r_hi;
  logic [SWEEP_W-1:0]   r_num, r_sweep;
  logic                 r_dir, r_cfg_err;

  logic [WIDTH-1:0]     w_q, w_q_inc, w_q_dec;
  logic [SWEEP_W-1:0]   w_sweep_plus;
  logic                 w_load, w_en, w_latch, w_sweep_inc, w_dir_next, w_cfg_next;

  assign w_q_inc      = WIDTH'(w_q + 1'b1);
  assign w_q_dec      = WIDTH'(w_q - 1'b1);
  assign w_sweep_plus = SWEEP_W'(r_sweep + 1'b1);

  sweep_count_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .data    (lo_bound),
    .en      (w_en),
    .up_down (r_dir),
    .q       (w_q)
  );

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_en        = 1'b0;
    w_latch     = 1'b0;
    w_sweep_inc = 1'b0;
    w_dir_next  = r_dir;
    w_cfg_next  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (lo_bound < hi_bound) begin
            w_latch    = 1'b1;
            w_load     = 1'b1;
            w_dir_next = DIR_UP;
            w_next     = UP;
          end else begin
            w_cfg_next = 1'b1;
          end
        end
      end
      UP: begin
        if (stop) begin
          w_next = DONE;
        end else begin
          w_en = 1'b1;
          if (w_q_inc == r_hi) begin
            w_next     = DOWN;
            w_dir_next = DIR_DOWN;
          end
        end
      end
      DOWN: begin
        if (stop) begin
          w_next = DONE;
        end else begin
          w_en = 1'b1;
          if (w_q_dec == r_lo) begin
            w_sweep_inc = 1'b1;
            w_dir_next  = DIR_UP;
            // num_sweeps of zero means run until stopped
            w_next      = ((r_num != '0) && (w_sweep_plus == r_num)) ? DONE : UP;
          end
        end
      end
      DONE: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_dir     <= DIR_UP;
      r_cfg_err <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_num     <= '0;
      r_sweep   <= '0;
    end else begin
      r_state   <= w_next;
      r_dir     <= w_dir_next;
      r_cfg_err <= w_cfg_next;
      if (w_latch) begin
        r_lo    <= lo_bound;
        r_hi    <= hi_bound;
        r_num   <= num_sweeps;
        r_sweep <= '0;
      end else if (w_sweep_inc) begin
        r_sweep <= w_sweep_plus;
      end
    end
  end

  assign cnt_out   = w_q;
  assign dir       = r_dir;
  assign busy      = (r_state == UP) || (r_state == DOWN);
  assign done      = (r_state == DONE);
  assign cfg_err   = r_cfg_err;
  assign sweep_cnt = r_sweep;

endmodule
